wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback result (ResultW from the W stage) and results returning from a long-latency execution unit such as a multiply/divide unit. Out-of-band results are buffered in a small FIFO. The block grants the port each cycle, preserves write ordering per destination register, prevents buffer starvation, and stalls the W stage when it takes the port away from the pipeline.

---
 rtl/wb_port_arbiter_if.sv | 25 ++
 rtl/wb_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback arbiter, the W stage, the long-latency unit and the
// register-file write port.
interface wb_port_arbiter_if;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        ml_valid;
    logic [4:0]  ml_rd;
    logic [31:0] ml_data;
    logic        ml_ready;
    logic        stall_w;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    modport slave (
        input  RegWriteW, RdW, ResultW, ml_valid, ml_rd, ml_data,
        output ml_ready, stall_w, rf_we, rf_rd, rf_wd
    );

    modport master (
        output RegWriteW, RdW, ResultW, ml_valid, ml_rd, ml_data,
        input  ml_ready, stall_w, rf_we, rf_rd, rf_wd
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the W stage and a buffered
// long-latency unit, keeping per-register write order and bounding buffer starvation.
module wb_port_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] DepthC     = CntW'(DEPTH);
    localparam logic [StW-1:0]  StarveMaxC = StW'(STARVE_MAX);
    localparam logic [PtrW-1:0] LastPtr    = PtrW'(DEPTH - 1);

    typedef enum logic [1:0] {SrcNone, SrcBuf, SrcMl, SrcPipe} src_e;

    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  occ_q, occ_d;
    logic [StW-1:0]   starve_q, starve_d;

    logic        empty, buf_match, hazard, pop, push, stall;
    logic [4:0]  sel_rd;
    logic [31:0] sel_wd;
    src_e        src;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (occ_q == '0);
    assign bus.ml_ready = (occ_q < DepthC);

    always_comb begin
        buf_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rd_q[i] == bus.RdW)) buf_match = 1'b1;
        end
    end

    assign hazard = bus.RegWriteW && (bus.RdW != 5'd0) &&
                    (buf_match || (bus.ml_valid && (bus.ml_rd == bus.RdW)));

    // Grant priority: forced drain, same-cycle ml collision, pipeline, drain, bypass.
    always_comb begin
        src      = SrcNone;
        stall    = 1'b0;
        pop      = 1'b0;
        starve_d = starve_q;
        if (!empty && ((starve_q == StarveMaxC) || hazard)) begin
            src      = SrcBuf;
            pop      = 1'b1;
            stall    = bus.RegWriteW;
            starve_d = '0;
        end else if (empty && hazard) begin
            src   = SrcMl;
            stall = 1'b1;
        end else if (bus.RegWriteW) begin
            src = SrcPipe;
            if (!empty && (starve_q != StarveMaxC)) starve_d = starve_q + 1'b1;
        end else if (!empty) begin
            src      = SrcBuf;
            pop      = 1'b1;
            starve_d = '0;
        end else if (bus.ml_valid) begin
            src = SrcMl;
        end
        if (empty) starve_d = '0;
    end

    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        unique case (src)
            SrcBuf:  begin sel_rd = rd_q[head_q]; sel_wd = data_q[head_q]; end
            SrcMl:   begin sel_rd = bus.ml_rd;    sel_wd = bus.ml_data;    end
            SrcPipe: begin sel_rd = bus.RdW;      sel_wd = bus.ResultW;    end
            default: begin sel_rd = '0;           sel_wd = '0;             end
        endcase
    end

    // Writes are suppressed during reset so discarded entries never reach the file.
    assign bus.rf_we   = (src != SrcNone) && (sel_rd != 5'd0) && !rst;
    assign bus.rf_rd   = sel_rd;
    assign bus.rf_wd   = sel_wd;
    assign bus.stall_w = stall && !rst;

    assign push = bus.ml_valid && bus.ml_ready && (src != SrcMl);

    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            rd_d[tail_q]   = bus.ml_rd;
            data_d[tail_q] = bus.ml_data;
            vld_d[tail_q]  = 1'b1;
            tail_d         = ptr_inc(tail_q);
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
            head_d        = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            occ_q    <= '0;
            starve_q <= '0;
        end else begin
            vld_q    <= vld_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            occ_q    <= occ_d;
            starve_q <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench: the driver queues hand-computed expectations per cycle and a
// negedge monitor pops and compares them against the write port.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        stall;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic vec(input string name, input bit r,
                       input bit rw, input logic [4:0] rdw, input logic [31:0] resw,
                       input bit mlv, input logic [4:0] mlrd, input logic [31:0] mld,
                       input bit we, input logic [4:0] erd, input logic [31:0] ewd,
                       input bit st, input bit rdy);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.RegWriteW = rw;
        bus.RdW       = rdw;
        bus.ResultW   = resw;
        bus.ml_valid  = mlv;
        bus.ml_rd     = mlrd;
        bus.ml_data   = mld;
        e.name  = name;
        e.we    = we;
        e.rd    = erd;
        e.wd    = ewd;
        e.stall = st;
        e.ready = rdy;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ((bus.rf_we !== e.we) || (bus.stall_w !== e.stall) ||
                    (bus.ml_ready !== e.ready) ||
                    (e.we && ((bus.rf_rd !== e.rd) || (bus.rf_wd !== e.wd)))) begin
                    errors++;
                    $display("FAIL %s: got we=%0b rd=%0d wd=%h stall=%0b ready=%0b, expected we=%0b rd=%0d wd=%h stall=%0b ready=%0b",
                             e.name, bus.rf_we, bus.rf_rd, bus.rf_wd, bus.stall_w, bus.ml_ready,
                             e.we, e.rd, e.wd, e.stall, e.ready);
                end
            end
        end
    end

    initial begin : driver
        bus.RegWriteW = 1'b0;
        bus.RdW       = '0;
        bus.ResultW   = '0;
        bus.ml_valid  = 1'b0;
        bus.ml_rd     = '0;
        bus.ml_data   = '0;
        repeat (2) @(posedge clk);

        //   name         rst rw rdW   resW          mlv mlrd  mld        we rd    wd            st rdy
        vec("pipe_x5",    0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,     1, 5'd5, 32'hDEADBEEF, 0, 1);
        vec("bypass_x7",  0, 0, 5'd0, 32'h0,        1, 5'd7, 32'h1234,  1, 5'd7, 32'h1234,     0, 1);
        vec("idle_empty", 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,     0, 5'd0, 32'h0,        0, 1);

        // Starvation: x20/x21 buffered, each forced out after four pipeline-won cycles.
        vec("st_x1",      0, 1, 5'd1, 32'h101, 1, 5'd20, 32'hA, 1, 5'd1,  32'h101, 0, 1);
        vec("st_x2",      0, 1, 5'd2, 32'h102, 1, 5'd21, 32'hB, 1, 5'd2,  32'h102, 0, 1);
        vec("st_x3_full", 0, 1, 5'd3, 32'h103, 0, 5'd0,  32'h0, 1, 5'd3,  32'h103, 0, 0);
        vec("st_x4",      0, 1, 5'd4, 32'h104, 0, 5'd0,  32'h0, 1, 5'd4,  32'h104, 0, 0);
        vec("st_x5",      0, 1, 5'd5, 32'h105, 0, 5'd0,  32'h0, 1, 5'd5,  32'h105, 0, 0);
        vec("st_force20", 0, 1, 5'd6, 32'h106, 0, 5'd0,  32'h0, 1, 5'd20, 32'hA,   1, 0);
        vec("st_x6",      0, 1, 5'd6, 32'h106, 0, 5'd0,  32'h0, 1, 5'd6,  32'h106, 0, 1);
        vec("st_x7",      0, 1, 5'd7, 32'h107, 0, 5'd0,  32'h0, 1, 5'd7,  32'h107, 0, 1);
        vec("st_x8",      0, 1, 5'd8, 32'h108, 0, 5'd0,  32'h0, 1, 5'd8,  32'h108, 0, 1);
        vec("st_x9",      0, 1, 5'd9, 32'h109, 0, 5'd0,  32'h0, 1, 5'd9,  32'h109, 0, 1);
        vec("st_force21", 0, 1, 5'd10, 32'h10A, 0, 5'd0, 32'h0, 1, 5'd21, 32'hB,   1, 1);
        vec("st_x10",     0, 1, 5'd10, 32'h10A, 0, 5'd0, 32'h0, 1, 5'd10, 32'h10A, 0, 1);
        vec("st_idle",    0, 0, 5'd0, 32'h0,   0, 5'd0,  32'h0, 0, 5'd0,  32'h0,   0, 1);

        // Buffered x3 must land before the younger pipeline x3.
        vec("ord_fill",   0, 1, 5'd9, 32'h99, 1, 5'd3, 32'h11, 1, 5'd9, 32'h99, 0, 1);
        vec("ord_old_x3", 0, 1, 5'd3, 32'h22, 0, 5'd0, 32'h0,  1, 5'd3, 32'h11, 1, 1);
        vec("ord_new_x3", 0, 1, 5'd3, 32'h22, 0, 5'd0, 32'h0,  1, 5'd3, 32'h22, 0, 1);
        vec("ord_idle",   0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 1);

        // Same-cycle collision on x4 with an empty buffer.
        vec("col_ml_x4",  0, 1, 5'd4, 32'h66, 1, 5'd4, 32'h55, 1, 5'd4, 32'h55, 1, 1);
        vec("col_pipe",   0, 1, 5'd4, 32'h66, 0, 5'd0, 32'h0,  1, 5'd4, 32'h66, 0, 1);
        vec("col_idle",   0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 1);

        // Buffered x0 is popped silently; a following ml result then bypasses.
        vec("x0_fill",    0, 1, 5'd8, 32'h88, 1, 5'd0, 32'h77, 1, 5'd8, 32'h88, 0, 1);
        vec("x0_pop",     0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 1);
        vec("x0_after",   0, 0, 5'd0, 32'h0,  1, 5'd6, 32'h66, 1, 5'd6, 32'h66, 0, 1);

        // Reset with two buffered entries discards them.
        vec("rst_fill1",  0, 1, 5'd1, 32'h1,  1, 5'd10, 32'hA0, 1, 5'd1, 32'h1, 0, 1);
        vec("rst_fill2",  0, 1, 5'd2, 32'h2,  1, 5'd11, 32'hB0, 1, 5'd2, 32'h2, 0, 1);
        vec("rst_cycle",  1, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 0, 0);
        vec("rst_after1", 0, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 0, 1);
        vec("rst_after2", 0, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 0, 1);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
